// File: rtl/eob_monitor.sv
// End-of-benchmark monitor: runs a cycle counter from the first SRAM request until an MMIO
// pass/fail write or a cycle-budget timeout, and counts SRAM reads that return nonzero taint.
module eob_monitor #(
    parameter int unsigned TimeoutCycles = 1000000,
    parameter logic [30:0] StopAddr      = 31'h0000_0000,
    parameter logic [30:0] FailBase      = 31'h0001_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [30:0] mmio_aw_addr_i,
    input  logic        mmio_aw_valid_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [63:0] mem_rdata_t0_i,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] exit_code_o,
    output logic [63:0] cycle_count_o,
    output logic [31:0] taint_reads_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [63:0] TimeoutLast = 64'(TimeoutCycles) - 64'd1;

    logic [1:0]  state_q, state_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [15:0] exit_code_q, exit_code_d;
    logic [63:0] cycle_count_q, cycle_count_d;
    logic [31:0] taint_q, taint_d;
    logic        rd_pending_q;

    logic        hit_stop, hit_fail, mmio_event;
    logic [63:0] count_inc;

    assign hit_stop   = mmio_aw_valid_i && (mmio_aw_addr_i == StopAddr);
    assign hit_fail   = mmio_aw_valid_i && (mmio_aw_addr_i[30:16] == FailBase[30:16]);
    assign mmio_event = hit_stop || hit_fail;
    assign count_inc  = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 64'd1;

    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        exit_code_d   = exit_code_q;
        cycle_count_d = cycle_count_q;
        taint_d       = taint_q;

        // A StopAddr hit wins over the fail window should the two ever overlap.
        if ((state_q != StDone) && mmio_event) begin
            state_d     = StDone;
            done_d      = 1'b1;
            pass_d      = hit_stop;
            timeout_d   = 1'b0;
            exit_code_d = hit_stop ? 16'h0000 : mmio_aw_addr_i[15:0];
        end else begin
            case (state_q)
                StIdle: begin
                    if (mem_req_i) begin
                        state_d       = StRun;
                        cycle_count_d = count_inc;
                    end
                end
                StRun: begin
                    if (cycle_count_q == TimeoutLast) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        pass_d      = 1'b0;
                        timeout_d   = 1'b1;
                        exit_code_d = 16'hFFFF;
                    end else begin
                        cycle_count_d = count_inc;
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end

        if ((state_q != StDone) && rd_pending_q && (|mem_rdata_t0_i) && (taint_q != '1)) begin
            taint_d = taint_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            exit_code_q   <= 16'h0000;
            cycle_count_q <= 64'd0;
            taint_q       <= 32'd0;
            rd_pending_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            exit_code_q   <= exit_code_d;
            cycle_count_q <= cycle_count_d;
            taint_q       <= taint_d;
            rd_pending_q  <= mem_req_i & ~mem_we_i;
        end
    end

    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign timeout_o     = timeout_q;
    assign exit_code_o   = exit_code_q;
    assign cycle_count_o = cycle_count_q;
    assign taint_reads_o = taint_q;

endmodule

// File: tb/tb_eob_monitor.sv
// Bench for eob_monitor: directed scenarios plus randomized traffic against a behavioural model,
// on two instances (default budget and an 8-cycle budget) sharing the same stimulus.
module tb_eob_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [30:0] addr = '0;
    logic        valid = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [63:0] rdata = '0;

    logic        a_done, a_pass, a_tmo;
    logic [15:0] a_code;
    logic [63:0] a_count;
    logic [31:0] a_taint;
    logic        b_done, b_pass, b_tmo;
    logic [15:0] b_code;
    logic [63:0] b_count;
    logic [31:0] b_taint;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    eob_monitor dut_a (
        .clk_i(clk), .rst_i(rst), .mmio_aw_addr_i(addr), .mmio_aw_valid_i(valid),
        .mem_req_i(req), .mem_we_i(we), .mem_rdata_t0_i(rdata),
        .done_o(a_done), .pass_o(a_pass), .timeout_o(a_tmo), .exit_code_o(a_code),
        .cycle_count_o(a_count), .taint_reads_o(a_taint)
    );

    eob_monitor #(.TimeoutCycles(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .mmio_aw_addr_i(addr), .mmio_aw_valid_i(valid),
        .mem_req_i(req), .mem_we_i(we), .mem_rdata_t0_i(rdata),
        .done_o(b_done), .pass_o(b_pass), .timeout_o(b_tmo), .exit_code_o(b_code),
        .cycle_count_o(b_count), .taint_reads_o(b_taint)
    );

    // Behavioural model: "finished" record plus a count of cycles spent running.
    typedef struct packed {
        logic        finished;
        logic        passed;
        logic        timed_out;
        logic [15:0] code;
        logic [63:0] run_cycles;
        logic [31:0] tainted;
        logic        running;
        logic        read_last;
    } model_t;

    model_t ma, mb;

    function automatic model_t model_step(model_t m, longint unsigned budget);
        model_t n = m;
        bit is_stop = valid && (addr == 31'h0);
        bit is_fail = valid && (addr[30:16] == 15'h1);
        if (!m.finished) begin
            if (m.read_last && rdata != 64'd0 && m.tainted != 32'hFFFF_FFFF)
                n.tainted = m.tainted + 1;
            if (is_stop || is_fail) begin
                n.finished = 1; n.passed = is_stop; n.timed_out = 0;
                n.code = is_stop ? 16'h0 : addr[15:0];
            end else if (m.running && m.run_cycles + 1 == budget) begin
                n.finished = 1; n.passed = 0; n.timed_out = 1; n.code = 16'hFFFF;
            end else if (m.running || req) begin
                n.running = 1;
                if (m.run_cycles != 64'hFFFF_FFFF_FFFF_FFFF) n.run_cycles = m.run_cycles + 1;
            end
        end
        n.read_last = req && !we;
        return n;
    endfunction

    task automatic step(input logic v, input logic [30:0] a, input logic rq, input logic w,
                        input logic [63:0] rd);
        valid = v; addr = a; req = rq; we = w; rdata = rd;
        @(posedge clk);
        ma = model_step(ma, 1000000);
        mb = model_step(mb, 8);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 31'h0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic do_reset();
        valid = 0; addr = '0; req = 0; we = 0; rdata = '0;
        rst = 1'b1;
        ma = '0;
        mb = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_done, a_pass, a_tmo, a_code, a_count, a_taint} !== '0) begin
            n_bad++;
            $display("FAIL reset_a: got %b%b%b %h %h %h, want all zero",
                     a_done, a_pass, a_tmo, a_code, a_count, a_taint);
        end
        n_cmp++;
        if ({b_done, b_pass, b_tmo, b_code, b_count, b_taint} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: got %b%b%b %h %h %h, want all zero",
                     b_done, b_pass, b_tmo, b_code, b_count, b_taint);
        end
        do_reset();
    endtask

    task automatic test_pass();
        do_reset();
        step(1'b0, 31'h0, 1'b1, 1'b0, 64'd0);
        idle(10);
        n_cmp++;
        if (a_count !== 64'd11 || a_done !== 1'b0) begin
            n_bad++;
            $display("FAIL pass_pre: count=%0d done=%b, want 11/0", a_count, a_done);
        end
        step(1'b1, 31'h0, 1'b0, 1'b0, 64'd0);
        n_cmp++;
        if ({a_done, a_pass, a_tmo, a_code, a_count} !== {3'b110, 16'h0, 64'd11}) begin
            n_bad++;
            $display("FAIL pass_done: done=%b pass=%b tmo=%b code=%h count=%0d, want 1/1/0/0000/11",
                     a_done, a_pass, a_tmo, a_code, a_count);
        end
        // DONE must ignore later writes and traffic.
        step(1'b1, 31'h1_0055, 1'b1, 1'b0, 64'd0);
        step(1'b0, 31'h0, 1'b1, 1'b0, 64'd1);
        n_cmp++;
        if ({a_done, a_pass, a_code, a_count, a_taint} !== {2'b11, 16'h0, 64'd11, 32'd0}) begin
            n_bad++;
            $display("FAIL pass_absorb: pass=%b code=%h count=%0d taint=%0d, want 1/0000/11/0",
                     a_pass, a_code, a_count, a_taint);
        end
    endtask

    task automatic test_fail_code();
        do_reset();
        step(1'b0, 31'h0, 1'b1, 1'b0, 64'd0);
        idle(3);
        step(1'b1, 31'h1_002A, 1'b0, 1'b0, 64'd0);
        n_cmp++;
        if ({a_done, a_pass, a_tmo, a_code} !== {3'b100, 16'h002A}) begin
            n_bad++;
            $display("FAIL fail_code: done=%b pass=%b tmo=%b code=%h, want 1/0/0/002a",
                     a_done, a_pass, a_tmo, a_code);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1'b0, 31'h0, 1'b1, 1'b0, 64'd0);
        idle(6);
        n_cmp++;
        if (b_count !== 64'd7 || b_done !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pre: count=%0d done=%b, want 7/0", b_count, b_done);
        end
        idle(1);
        n_cmp++;
        if ({b_done, b_pass, b_tmo, b_code, b_count} !== {3'b101, 16'hFFFF, 64'd7}) begin
            n_bad++;
            $display("FAIL timeout_done: done=%b pass=%b tmo=%b code=%h count=%0d, want 1/0/1/ffff/7",
                     b_done, b_pass, b_tmo, b_code, b_count);
        end
    endtask

    task automatic test_timeout_race();
        do_reset();
        step(1'b0, 31'h0, 1'b1, 1'b0, 64'd0);
        idle(6);
        step(1'b1, 31'h0, 1'b0, 1'b0, 64'd0);
        n_cmp++;
        if ({b_done, b_pass, b_tmo, b_code} !== {3'b110, 16'h0}) begin
            n_bad++;
            $display("FAIL timeout_race: done=%b pass=%b tmo=%b code=%h, want 1/1/0/0000",
                     b_done, b_pass, b_tmo, b_code);
        end
    endtask

    task automatic test_taint();
        do_reset();
        step(1'b0, 31'h0, 1'b1, 1'b0, 64'd0);
        step(1'b0, 31'h0, 1'b1, 1'b0, 64'd1);
        step(1'b0, 31'h0, 1'b1, 1'b0, 64'd0);
        step(1'b0, 31'h0, 1'b1, 1'b1, 64'h8000_0000_0000_0000);
        step(1'b0, 31'h0, 1'b0, 1'b0, 64'hFFFF);
        n_cmp++;
        if (a_taint !== 32'd2) begin
            n_bad++;
            $display("FAIL taint_count: got %0d, want 2", a_taint);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        // Stop write and request together in IDLE: the write wins.
        step(1'b1, 31'h0, 1'b1, 1'b0, 64'd0);
        n_cmp++;
        if ({a_done, a_pass, a_count} !== {2'b11, 64'd0}) begin
            n_bad++;
            $display("FAIL idle_priority: done=%b pass=%b count=%0d, want 1/1/0",
                     a_done, a_pass, a_count);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_done, a_pass, a_tmo, a_code, a_count, a_taint} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %b%b%b %h %h %h, want all zero",
                     a_done, a_pass, a_tmo, a_code, a_count, a_taint);
        end
        ma = '0;
        mb = '0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 31'h5, 1'b0, 1'b0, 64'd0);
        n_cmp++;
        if (a_done !== 1'b0 || a_count !== 64'd0) begin
            n_bad++;
            $display("FAIL ignore_addr5: done=%b count=%0d, want 0/0", a_done, a_count);
        end
        step(1'b0, 31'h0, 1'b1, 1'b0, 64'd0);
        n_cmp++;
        if (a_done !== 1'b0 || a_count !== 64'd1) begin
            n_bad++;
            $display("FAIL restart_run: done=%b count=%0d, want 0/1", a_done, a_count);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                logic        v;
                logic [30:0] a;
                logic [63:0] rd;
                int unsigned sel;
                v   = ($urandom % (8 + 20 * t)) == 0;
                sel = $urandom % 3;
                if (sel == 0) a = 31'h0;
                else if (sel == 1) a = {15'h1, 16'($urandom)};
                else a = 31'($urandom);
                rd = ($urandom % 2 == 0) ? 64'd0 : (64'd1 << ($urandom % 64));
                step(v, a, 1'($urandom), ($urandom % 3) == 0, rd);
                n_cmp++;
                if ({a_done, a_pass, a_tmo, a_code, a_count, a_taint} !==
                    {ma.finished, ma.passed, ma.timed_out, ma.code, ma.run_cycles, ma.tainted}) begin
                    n_bad++;
                    $display("FAIL random_a t%0d c%0d: got %b%b%b %h %h %h, want %b%b%b %h %h %h",
                             t, c, a_done, a_pass, a_tmo, a_code, a_count, a_taint,
                             ma.finished, ma.passed, ma.timed_out, ma.code, ma.run_cycles,
                             ma.tainted);
                end
                n_cmp++;
                if ({b_done, b_pass, b_tmo, b_code, b_count, b_taint} !==
                    {mb.finished, mb.passed, mb.timed_out, mb.code, mb.run_cycles, mb.tainted}) begin
                    n_bad++;
                    $display("FAIL random_b t%0d c%0d: got %b%b%b %h %h %h, want %b%b%b %h %h %h",
                             t, c, b_done, b_pass, b_tmo, b_code, b_count, b_taint,
                             mb.finished, mb.passed, mb.timed_out, mb.code, mb.run_cycles,
                             mb.tainted);
                end
            end
        end
    endtask

    initial begin
        ma = '0;
        mb = '0;
        #12;
        test_reset();
        test_pass();
        test_fail_code();
        test_timeout();
        test_timeout_race();
        test_taint();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eob_monitor.md
EOB_MONITOR -- requirements
Module: eob_monitor

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 1000000, meaning the RUN-state cycle budget before a forced stop (legal range >= 2).
REQ-002 SHALL have parameter StopAddr, 31 bits, default 31'h0000_0000, meaning the MMIO write address that signals a passing end of benchmark.
REQ-003 SHALL have parameter FailBase, 31 bits, default 31'h0001_0000, meaning the base of a 64 KiB MMIO window that signals failure, with the exit code in the low 16 bits.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port mmio_aw_addr_i, input, 31 bits, the end-of-benchmark MMIO write address.
REQ-007 SHALL have port mmio_aw_valid_i, input, 1 bit, qualifying mmio_aw_addr_i.
REQ-008 SHALL have port mem_req_i, input, 1 bit, the SRAM request strobe.
REQ-009 SHALL have port mem_we_i, input, 1 bit, the SRAM write enable.
REQ-010 SHALL have port mem_rdata_t0_i, input, 64 bits, the SRAM read-data taint, valid one cycle after a read request.
REQ-011 SHALL have port done_o, output, 1 bit, asserted in state DONE.
REQ-012 SHALL have port pass_o, output, 1 bit, asserted when DONE was reached via StopAddr.
REQ-013 SHALL have port timeout_o, output, 1 bit, asserted when DONE was reached via timeout.
REQ-014 SHALL have port exit_code_o, output, 16 bits, the fail code.
REQ-015 SHALL have port cycle_count_o, output, 64 bits, the number of cycles spent in RUN.
REQ-016 SHALL have port taint_reads_o, output, 32 bits, the count of reads returning nonzero taint.

Function
REQ-017 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-018 SHALL leave IDLE when mem_req_i=1 and enter RUN on the next cycle.
REQ-019 SHALL treat an MMIO event as the condition mmio_aw_valid_i=1 and mmio_aw_addr_i==StopAddr, or mmio_aw_valid_i=1 and mmio_aw_addr_i[30:16]==FailBase[30:16].
REQ-020 SHALL, on an MMIO event in IDLE or RUN, enter DONE on the next cycle; in IDLE the MMIO event takes priority over mem_req_i.
REQ-021 SHALL, on entering DONE via StopAddr, latch pass_o=1, timeout_o=0 and exit_code_o=0.
REQ-022 SHALL, on entering DONE via the fail window, latch pass_o=0, timeout_o=0 and exit_code_o=mmio_aw_addr_i[15:0].
REQ-023 SHALL increment cycle_count_o by 1 on every cycle in RUN, starting at 1 on the first RUN cycle, and hold it in IDLE and DONE.
REQ-024 SHALL, in RUN when cycle_count_o==TimeoutCycles-1 and no MMIO event is present, enter DONE with timeout_o=1, pass_o=0 and exit_code_o=16'hFFFF.
REQ-025 SHALL, when an MMIO event and the timeout condition occur in the same cycle, give the MMIO event priority.
REQ-026 SHALL make DONE absorbing: all later MMIO writes are ignored and all outputs are frozen until reset.
REQ-027 SHALL register rd_pending = mem_req_i & ~mem_we_i every cycle, in every state.
REQ-028 SHALL increment taint_reads_o when rd_pending=1 and mem_rdata_t0_i is nonzero, only in IDLE or RUN.
REQ-029 SHALL saturate taint_reads_o at 32'hFFFF_FFFF.
REQ-030 SHALL saturate cycle_count_o at all-ones.
REQ-031 SHALL drive done_o, pass_o and timeout_o directly from registers, with no combinational path from any input.
REQ-032 SHALL ignore MMIO writes outside StopAddr and the fail window.

Reset
REQ-033 SHALL, while rst_i=1, asynchronously force state=IDLE, done_o=0, pass_o=0, timeout_o=0, exit_code_o=0, cycle_count_o=0, taint_reads_o=0 and rd_pending=0.
REQ-034 SHALL, on reset asserted mid-RUN or in DONE, discard all results and restart from IDLE after deassertion.

Verification
REQ-035 Bench SHALL cover: mem_req_i pulse, 10 cycles later a write to 0x0 -> done_o=1, pass_o=1, cycle_count_o=11, exit_code_o=0.
REQ-036 Bench SHALL cover: in RUN, a write to 0x1_002A -> done_o=1, pass_o=0, exit_code_o=16'h002A.
REQ-037 Bench SHALL cover: TimeoutCycles=8 with no MMIO write -> done_o=1 and timeout_o=1 with cycle_count_o=7, exit_code_o=16'hFFFF.
REQ-038 Bench SHALL cover: TimeoutCycles=8 with a StopAddr write in the cycle where cycle_count_o=7 -> pass_o=1, timeout_o=0.
REQ-039 Bench SHALL cover: 3 reads with mem_rdata_t0_i=0x1, 0x0 and 0x8000_0000_0000_0000 in the following cycles, and 1 write with nonzero taint -> taint_reads_o=2.
REQ-040 Bench SHALL cover: rst_i asserted asynchronously in DONE, mid-cycle -> all outputs 0 immediately; a write to 0x5 after release -> remains in IDLE.
